mips_multicycle_control: RTL

//  Multicycle main controller for the MIPS core. Sequences the shared ALU, memory

---
 rtl/mips_ctrl_pkg.sv | 77 +++++++
 rtl/mips_multicycle_control_if.sv | 42 ++++
 rtl/mips_ctrl_outdec.sv | 92 +++++++++
 rtl/mips_multicycle_control.sv | 92 +++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// mips_ctrl_pkg : shared constants, state codes and control word for the
//                 MIPS multicycle controller.       Rev 1.0
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [1:0] ALUSRCB_REG    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_FETCH  = 4'd1;
  localparam state_t S_DECODE = 4'd2;
  localparam state_t S_MEMADR = 4'd3;
  localparam state_t S_MEMRD  = 4'd4;
  localparam state_t S_MEMWB  = 4'd5;
  localparam state_t S_MEMWR  = 4'd6;
  localparam state_t S_EXEC   = 4'd7;
  localparam state_t S_RWB    = 4'd8;
  localparam state_t S_BRANCH = 4'd9;
  localparam state_t S_ADDIEX = 4'd10;
  localparam state_t S_SLTIEX = 4'd11;
  localparam state_t S_IWB    = 4'd12;
  localparam state_t S_JUMP   = 4'd13;
  localparam state_t S_JR     = 4'd14;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_word_t;

  function automatic logic opcode_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_control_if.sv
// ============================================================================
// mips_multicycle_control_if : controller <-> datapath control bus.
//                              Rev 1.0
// ============================================================================
`default_nettype none

interface mips_multicycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Func;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOP;
  logic [1:0] PCSource;
  logic       Illegal;

  modport master (
    input  Opcode, Func, Zero, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP,
           PCSource, Illegal
  );

  modport slave (
    output Opcode, Func, Zero, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP,
           PCSource, Illegal
  );
endinterface

`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
// ============================================================================
// mips_ctrl_outdec : state -> control word decoder (Moore, plus FETCH handshake
//                    and DECODE illegal-opcode pulse).     Rev 1.0
// ============================================================================
`default_nettype none

module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = ALUSRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.pc_source = PCSRC_ALU;
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      S_DECODE: begin
        cw.alu_src_b = ALUSRCB_IMM_SH;
        cw.alu_op    = ALUOP_ADD;
        cw.illegal   = ~opcode_supported(opcode);
      end
      S_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = ALUSRCB_REG;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        cw.reg_dst   = 1'b1;
        cw.reg_write = 1'b1;
      end
      S_MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = ALUSRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      S_MEMWB: begin
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = ALUSRCB_REG;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = ALUSRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_SLTIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = ALUSRCB_IMM;
        cw.alu_op    = ALUOP_SLT;
      end
      S_IWB: begin
        cw.reg_write = 1'b1;
      end
      S_JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_JUMP;
      end
      S_JR: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_REGA;
      end
      default: cw = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_control.sv
// ============================================================================
// mips_multicycle_control : multicycle MIPS main controller FSM.
//                           Rev 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mips_multicycle_control_if.master  bus
);

  localparam int          CNT_W     = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD) : 1;
  localparam int unsigned HOLD_LAST = (RESET_PC_HOLD > 0) ? RESET_PC_HOLD - 1 : 0;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic               w_hold_done;
  ctrl_word_t         w_cw;
  logic               w_unused_zero;

  // Zero qualifies PCWriteCond in the datapath, not here.
  assign w_unused_zero = bus.Zero;
  assign w_hold_done   = (r_hold_cnt == CNT_W'(HOLD_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && !w_hold_done)
        r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_hold_done)  w_next_state = S_FETCH;
      S_FETCH:  if (bus.MemReady) w_next_state = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_RTYPE:     w_next_state = (bus.Func == FN_JR) ? S_JR : S_EXEC;
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_SLTI:      w_next_state = S_SLTIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: w_next_state = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.MemReady) w_next_state = S_MEMWB;
      S_MEMWR:  if (bus.MemReady) w_next_state = S_FETCH;
      S_EXEC:   w_next_state = S_RWB;
      S_ADDIEX, S_SLTIEX: w_next_state = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JR: w_next_state = S_FETCH;
      default:  w_next_state = S_IDLE;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state     (r_state),
    .opcode    (bus.Opcode),
    .mem_ready (bus.MemReady),
    .cw        (w_cw)
  );

  assign bus.PCWrite     = w_cw.pc_write;
  assign bus.PCWriteCond = w_cw.pc_write_cond;
  assign bus.IorD        = w_cw.iord;
  assign bus.MemRead     = w_cw.mem_read;
  assign bus.MemWrite    = w_cw.mem_write;
  assign bus.IRWrite     = w_cw.ir_write;
  assign bus.MemtoReg    = w_cw.mem_to_reg;
  assign bus.RegDst      = w_cw.reg_dst;
  assign bus.RegWrite    = w_cw.reg_write;
  assign bus.ALUSrcA     = w_cw.alu_src_a;
  assign bus.ALUSrcB     = w_cw.alu_src_b;
  assign bus.ALUOP       = w_cw.alu_op;
  assign bus.PCSource    = w_cw.pc_source;
  assign bus.Illegal     = w_cw.illegal;

endmodule

`default_nettype wire
